// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter: one owner of a shared resource at a time.
// Ports: clk, rst_n, req[N], done -> grant[N], busy, owner_id, timeout_err.
module rr_grant_fsm #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [IDW-1:0] owner_id,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    COOL  = 2'b10
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t         state;
  logic [CW-1:0]  hold_cnt;
  logic [IDW-1:0] ptr;

  logic [IDW-1:0] sel;
  logic           found;
  logic [IDW-1:0] ptr_nxt;
  logic           own_req;
  logic           at_limit;

  // First requester at or above ptr, wrapping modulo N.
  always_comb begin
    int j;
    j     = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[IDW'(j)]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
  end

  assign own_req  = req[owner_id];
  assign at_limit = (hold_cnt == HOLD_LAST);

  // Next search starts just past the releasing owner.
  assign ptr_nxt = (int'(owner_id) == N - 1) ?
                   '0 : owner_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      owner_id    <= '0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= '0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            grant    <= N'(1) << sel;
            busy     <= 1'b1;
            owner_id <= sel;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (done || !own_req || at_limit) begin
            state <= COOL;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_nxt;
            // Only a pure timeout release is flagged.
            timeout_err <= !done && own_req;
          end else if (!at_limit) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        COOL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  a_grant_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    (grant != '0) == (state == GRANT));

  a_hold_max: assert property (
    @(posedge clk) disable iff (!rst_n)
    hold_cnt <= HOLD_LAST);
`endif

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed bench for rr_grant_fsm (N=4, MAX_HOLD=16).
// One task per scenario; outputs sampled 1ns after posedge.
module tb_rr_grant_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] owner_id;
  logic       timeout_err;

  int n_tests;
  int n_fail;

  // {grant, owner_id, busy, timeout_err}
  logic [7:0] obs;
  assign obs = {grant, owner_id, busy, timeout_err};

  rr_grant_fsm #(
    .N(4), .IDW(2), .MAX_HOLD(16), .CW(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant(grant),
    .busy(busy),
    .owner_id(owner_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    tick();
    n_tests++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs, 8'b0);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL idle_no_req: got %b want %b", obs, 8'b0);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    n_tests++;
    if (obs !== 8'b0100_10_1_0) begin
      n_fail++;
      $display("FAIL single_grant: got %b want %b",
               obs, 8'b0100_10_1_0);
    end
    done = 1'b1;
    tick();
    n_tests++;
    if (obs !== 8'b0000_10_0_0) begin
      n_fail++;
      $display("FAIL single_cool: got %b want %b",
               obs, 8'b0000_10_0_0);
    end
    done = 1'b0;
    req  = 4'b1111;
    tick();
    n_tests++;
    if (obs !== 8'b0000_10_0_0) begin
      n_fail++;
      $display("FAIL single_idle_gap: got %b want %b",
               obs, 8'b0000_10_0_0);
    end
    // ptr must now be 3
    tick();
    n_tests++;
    if (obs !== 8'b1000_11_1_0) begin
      n_fail++;
      $display("FAIL ptr_after_2: got %b want %b",
               obs, 8'b1000_11_1_0);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp_g  = 4'b0001 << exp_id;
      tick();
      n_tests++;
      if (obs !== {exp_g, exp_id, 2'b10}) begin
        n_fail++;
        $display("FAIL rotate_%0d: got %b want %b",
                 k, obs, {exp_g, exp_id, 2'b10});
      end
      tick();
      tick();
      n_tests++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL rotate_hold_%0d: got %b want %b",
                 k, grant, exp_g);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_tests++;
      if ({grant, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL rotate_cool_%0d: got %b want %b",
                 k, {grant, busy}, 5'b0);
      end
      tick();
      n_tests++;
      if ({grant, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL rotate_idle_%0d: got %b want %b",
                 k, {grant, busy}, 5'b0);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req = 4'b0001;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (obs !== 8'b0001_00_1_0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_hold16: got %0d bad cycles want 0",
               bad);
    end
    n_tests++;
    if (obs !== 8'b0000_00_0_1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %b want %b",
               obs, 8'b0000_00_0_1);
    end
    tick();
    n_tests++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL timeout_one_cycle: got %b want %b",
               obs, 8'b0000_00_0_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b0001_00_1_0) begin
      n_fail++;
      $display("FAIL timeout_regrant: got %b want %b",
               obs, 8'b0001_00_1_0);
    end
  endtask

  // Continues from the regrant in test_timeout.
  task automatic test_done_at_limit();
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL limit_still_held: got %b want %b",
               grant, 4'b0001);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    n_tests++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL done_beats_timeout: got %b want %b",
               obs, 8'b0000_00_0_0);
    end
    tick();
    tick();
  endtask

  task automatic test_drop();
    // ptr = 1 here
    req = 4'b1010;
    tick();
    n_tests++;
    if (obs !== 8'b0010_01_1_0) begin
      n_fail++;
      $display("FAIL drop_grant1: got %b want %b",
               obs, 8'b0010_01_1_0);
    end
    tick();
    req = 4'b1000;
    tick();
    n_tests++;
    if (obs !== 8'b0000_01_0_0) begin
      n_fail++;
      $display("FAIL drop_release: got %b want %b",
               obs, 8'b0000_01_0_0);
    end
    tick();
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_idle_gap: got %b want %b",
               grant, 4'b0000);
    end
    tick();
    n_tests++;
    if (obs !== 8'b1000_11_1_0) begin
      n_fail++;
      $display("FAIL drop_pending3: got %b want %b",
               obs, 8'b1000_11_1_0);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_done_outside();
    // ptr = 0, done held in IDLE must not block a grant
    done = 1'b1;
    req  = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    n_tests++;
    if (obs !== 8'b0010_01_1_0) begin
      n_fail++;
      $display("FAIL done_in_idle: got %b want %b",
               obs, 8'b0010_01_1_0);
    end
    tick();
    done = 1'b0;
    req  = '0;
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL done_in_grant: got %b want %b",
               grant, 4'b0000);
    end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    // ptr = 2
    req = 4'b0100;
    tick();
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL areset_pre: got %b want %b",
               grant, 4'b0100);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 8'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %b want %b",
               obs, 8'b0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b0) begin
      n_fail++;
      $display("FAIL areset_hold: got %b want %b",
               obs, 8'b0);
    end
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    n_tests++;
    if (obs !== 8'b0001_00_1_0) begin
      n_fail++;
      $display("FAIL areset_ptr0: got %b want %b",
               obs, 8'b0001_00_1_0);
    end
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_rotate();
    test_timeout();
    test_done_at_limit();
    test_drop();
    test_done_outside();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
